// File: rtl/alu_operand_sequencer.sv
// Operand feeder and result capture stage for an external 8-bit combinational ALU.
// Collects A, B and mode bytes over valid/ready, waits SETTLE_CYCLES, then presents the result.
module alu_operand_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_m,
  input  logic [7:0] alu_out,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic [7:0] ops_done
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_M,
    EXEC,
    HOLD
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       load_a;
  logic       load_b;
  logic       load_m;
  logic       capture;
  logic       retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  // in_ready and busy depend on state alone, so in_valid never reaches in_ready combinationally.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_m     = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load_a     = 1'b1;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_b     = 1'b1;
          state_next = LOAD_M;
        end
      end
      LOAD_M: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_m     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (settle_cnt == SETTLE_LAST) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          retire     = 1'b1;
          state_next = LOAD_A;
        end
      end
      default: begin
        state_next = LOAD_A;
      end
    endcase
  end

  // Operands persist after an operation until their own byte is reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_m      <= 1'b0;
      settle_cnt <= 4'd0;
    end else begin
      if (load_a) begin
        alu_a <= in_data;
      end
      if (load_b) begin
        alu_b <= in_data;
      end
      if (load_m) begin
        alu_m      <= in_data[0];
        settle_cnt <= 4'd0;
      end else if (state == EXEC && !capture) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data  <= 8'h00;
      res_valid <= 1'b0;
      ops_done  <= 8'h00;
    end else begin
      if (capture) begin
        res_data  <= alu_out;
        res_valid <= 1'b1;
      end else if (retire) begin
        res_valid <= 1'b0;
        ops_done  <= ops_done + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: two instances (settle 1 and settle 4) each driving a behavioural ALU,
// directed and randomized operations checked against an arithmetic reference model.
module tb_alu_operand_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      reset;
  logic [1:0][7:0] in_data;
  logic [1:0]      in_valid;
  logic [1:0]      in_ready;
  logic [1:0][7:0] alu_a;
  logic [1:0][7:0] alu_b;
  logic [1:0]      alu_m;
  logic [1:0][7:0] alu_out;
  logic [1:0][7:0] res_data;
  logic [1:0]      res_valid;
  logic [1:0]      res_ready;
  logic [1:0]      busy;
  logic [1:0][7:0] ops_done;

  int total = 0;
  int bad   = 0;
  int exp_ops [2];

  // The ALU under the sequencer: mode 0 adds, mode 1 subtracts.
  assign alu_out[0] = alu_m[0] ? (alu_a[0] - alu_b[0]) : (alu_a[0] + alu_b[0]);
  assign alu_out[1] = alu_m[1] ? (alu_a[1] - alu_b[1]) : (alu_a[1] + alu_b[1]);

  alu_operand_sequencer #(.SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset[0]), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_m(alu_m[0]), .alu_out(alu_out[0]),
    .res_data(res_data[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .busy(busy[0]), .ops_done(ops_done[0])
  );

  alu_operand_sequencer #(.SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset[1]), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_m(alu_m[1]), .alu_out(alu_out[1]),
    .res_data(res_data[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .busy(busy[1]), .ops_done(ops_done[1])
  );

  function automatic int settleOf(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] aluModel(input int a, input int b, input int m);
    if (m % 2 == 1) return 8'((a - b + 256) % 256);
    return 8'((a + b) % 256);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic checkReset(input int u);
    checkOutput("rst_in_ready", in_ready[u], 1);
    checkOutput("rst_busy", busy[u], 0);
    checkOutput("rst_alu_a", alu_a[u], 0);
    checkOutput("rst_alu_b", alu_b[u], 0);
    checkOutput("rst_alu_m", alu_m[u], 0);
    checkOutput("rst_res_data", res_data[u], 0);
    checkOutput("rst_res_valid", res_valid[u], 0);
    checkOutput("rst_ops_done", ops_done[u], 0);
  endtask

  // Offers one byte after 'gap' idle cycles; returns just after the accepting edge.
  task automatic applyStimulus(input int u, input logic [7:0] d, input int gap, input bit after_first);
    bit taken = 0;
    in_valid[u] = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checkOutput("gap_in_ready", in_ready[u], 1);
      checkOutput("gap_busy", busy[u], after_first ? 1 : 0);
      @(posedge clk);
      #1;
    end
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready[u]) begin
        @(posedge clk);
        #1;
        taken = 1;
        break;
      end
    end
    in_valid[u] = 1'b0;
    checkOutput("accept_timeout", taken, 1);
  endtask

  task automatic runOp(input int u, input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input int gap, input int hold);
    logic [7:0] expected;
    int first;
    expected     = aluModel(a, b, m);
    first        = -1;
    res_ready[u] = (hold == 0);
    applyStimulus(u, a, gap, 0);
    checkOutput("load_a", alu_a[u], a);
    applyStimulus(u, b, gap, 1);
    checkOutput("load_b", alu_b[u], b);
    checkOutput("keep_a", alu_a[u], a);
    applyStimulus(u, m, gap, 1);
    checkOutput("load_m", alu_m[u], m[0]);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (res_valid[u]) begin
        first = n;
        break;
      end
      checkOutput("exec_busy", busy[u], 1);
      checkOutput("exec_in_ready", in_ready[u], 0);
    end
    checkOutput("latency", first, settleOf(u));
    checkOutput("res_data", res_data[u], expected);
    checkOutput("hold_in_ready", in_ready[u], 0);
    checkOutput("hold_busy", busy[u], 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      in_valid[u] = 1'b1;
      in_data[u]  = 8'($urandom);
      @(negedge clk);
      checkOutput("bp_res_valid", res_valid[u], 1);
      checkOutput("bp_res_data", res_data[u], expected);
      checkOutput("bp_in_ready", in_ready[u], 0);
      checkOutput("bp_alu_a", alu_a[u], a);
      checkOutput("bp_alu_b", alu_b[u], b);
      checkOutput("bp_alu_m", alu_m[u], m[0]);
      checkOutput("bp_ops_done", ops_done[u], exp_ops[u]);
    end
    in_valid[u]  = 1'b0;
    res_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    exp_ops[u] = (exp_ops[u] + 1) % 256;
    checkOutput("post_res_valid", res_valid[u], 0);
    checkOutput("post_ops_done", ops_done[u], exp_ops[u]);
    checkOutput("post_in_ready", in_ready[u], 1);
    checkOutput("post_busy", busy[u], 0);
  endtask

  initial begin
    bit seen;
    reset      = 2'b11;
    in_valid   = 2'b00;
    in_data    = '0;
    res_ready  = 2'b00;
    exp_ops[0] = 0;
    exp_ops[1] = 0;
    #12;
    checkReset(0);
    checkReset(1);
    @(negedge clk);
    reset = 2'b00;
    @(posedge clk);
    #1;

    $display("[TB] basic add, wrap, mode masking, backpressure");
    runOp(0, 8'h12, 8'h34, 8'h00, 0, 0);
    runOp(0, 8'hFF, 8'h01, 8'h00, 0, 0);
    runOp(0, 8'h80, 8'h80, 8'hFE, 1, 0);
    checkOutput("mode_mask", alu_m[0], 0);
    runOp(0, 8'h3C, 8'h1A, 8'h01, 0, 10);

    $display("[TB] reset during EXEC and HOLD");
    res_ready[1] = 1'b1;
    applyStimulus(1, 8'hAA, 0, 0);
    applyStimulus(1, 8'h55, 0, 1);
    applyStimulus(1, 8'h01, 0, 1);
    #2;
    reset[1] = 1'b1;
    #1;
    checkReset(1);
    exp_ops[1] = 0;
    @(negedge clk);
    reset[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("exec_rst_res_valid", res_valid[1], 0);
      checkOutput("exec_rst_ops_done", ops_done[1], 0);
    end
    @(posedge clk);
    #1;
    res_ready[1] = 1'b0;
    applyStimulus(1, 8'h21, 0, 0);
    applyStimulus(1, 8'h43, 0, 1);
    applyStimulus(1, 8'h00, 0, 1);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (res_valid[1]) begin
        seen = 1;
        break;
      end
    end
    checkOutput("hold_reached", seen, 1);
    @(posedge clk);
    #3;
    reset[1] = 1'b1;
    #1;
    checkReset(1);
    exp_ops[1] = 0;
    @(negedge clk);
    reset[1]     = 1'b0;
    res_ready[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("hold_rst_res_valid", res_valid[1], 0);
      checkOutput("hold_rst_ops_done", ops_done[1], 0);
    end
    @(posedge clk);
    #1;
    runOp(1, 8'h05, 8'h03, 8'h00, 0, 0);
    checkOutput("after_rst_sum", res_data[1], 8'h08);

    $display("[TB] gapped bytes with long settle");
    for (int i = 0; i < 4; i++) begin
      runOp(1, 8'($urandom), 8'($urandom), 8'($urandom), 3, (i == 2) ? 3 : 0);
    end

    $display("[TB] 256 random operations for counter wrap");
    @(posedge clk);
    #3;
    reset[0] = 1'b1;
    #1;
    checkReset(0);
    exp_ops[0] = 0;
    @(negedge clk);
    reset[0] = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      runOp(0, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0) ? 2 : 0);
    end
    checkOutput("ops_wrap", ops_done[0], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
